fifo_pop_router: RTL and testbench

Downstream consumer stage of the 8-entry, 10-bit FIFO. Pops words whenever the FIFO is non-empty and no destination is near full, then routes each word to one of four destination queues using the destination field `data[9:8]`. Presents a single registered data bus with one push strobe per destination, and latches a sticky error state when the FIFO reports an error.

---
 rtl/fifo_pop_router.sv | 122 ++++++++++++
 tb/tb_fifo_pop_router.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_router.sv
// fifo_pop_router: pops a FIFO and routes each word to one of 4 queues.
// Optional per-destination push counters: define ROUTER_STATS_EN.
module fifo_pop_router #(
  parameter int DATA_WIDTH = 10,
  parameter int STAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read_enable,
  input  logic [3:0]            dest_almost_full,
  output logic [3:0]            push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            state,
  output logic                  idle
`ifdef ROUTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] pop_count0,
  output logic [STAT_WIDTH-1:0] pop_count1,
  output logic [STAT_WIDTH-1:0] pop_count2,
  output logic [STAT_WIDTH-1:0] pop_count3
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       inflight;
  logic       any_full;
  logic       pop_ok;
  logic       deliver;
  logic [1:0] dest;
  logic [3:0] push_d;

  assign any_full = |dest_almost_full;
  assign pop_ok   = (state_q != ERROR)
                  & ~fifo_empty
                  & ~any_full;

  // reset gates the pop so the FIFO is never read while held in reset
  assign fifo_read_enable = reset & pop_ok;

  assign dest = fifo_data_out[DATA_WIDTH-1 -: 2];

  // an in-flight word is dropped if this edge enters (or stays in) ERROR
  assign deliver = inflight & (state_d != ERROR);

  assign state = state_q;
  assign idle  = (state_q == IDLE)
               & ~inflight
               & (push == 4'b0000);

  // next-state: error wins over every other transition
  always_comb begin
    state_d = state_q;
    if (fifo_error) begin
      state_d = ERROR;
    end else begin
      unique case (state_q)
        IDLE:    if (pop_ok) state_d = ACTIVE;
        ACTIVE:  if (fifo_empty | any_full) state_d = IDLE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // one-hot destination strobe for the word arriving this cycle
  always_comb begin
    push_d = 4'b0000;
    if (deliver) begin
      unique case (dest)
        2'd0:    push_d = 4'b0001;
        2'd1:    push_d = 4'b0010;
        2'd2:    push_d = 4'b0100;
        default: push_d = 4'b1000;
      endcase
    end
  end

  // state, in-flight tracking and the registered output bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      inflight <= 1'b0;
      push     <= 4'b0000;
      data_out <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= fifo_read_enable;
      push     <= push_d;
      if (deliver) data_out <= fifo_data_out;
    end
  end

`ifdef ROUTER_STATS_EN
  logic [STAT_WIDTH-1:0] cnt [4];

  // per-destination push counters; wrap naturally, cleared by reset only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (push_d[i]) cnt[i] <= cnt[i] + STAT_WIDTH'(1);
    end
  end

  assign pop_count0 = cnt[0];
  assign pop_count1 = cnt[1];
  assign pop_count2 = cnt[2];
  assign pop_count3 = cnt[3];
`endif

endmodule

// File: tb/tb_fifo_pop_router.sv
// tb_fifo_pop_router: scoreboard bench with a queue-based FIFO model.
// Build with ROUTER_STATS_EN to also exercise the counters.
module tb_fifo_pop_router;
  localparam int DW = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_error = 1'b0;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_read_enable;
  logic [3:0]    dest_almost_full = 4'b0000;
  logic [3:0]    push;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic          idle;
`ifdef ROUTER_STATS_EN
  logic [SW-1:0] pop_count0;
  logic [SW-1:0] pop_count1;
  logic [SW-1:0] pop_count2;
  logic [SW-1:0] pop_count3;
`endif

  fifo_pop_router #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_error(fifo_error),
    .fifo_data_out(fifo_data_out),
    .fifo_read_enable(fifo_read_enable),
    .dest_almost_full(dest_almost_full),
    .push(push),
    .data_out(data_out),
    .state(state),
    .idle(idle)
`ifdef ROUTER_STATS_EN
    ,
    .pop_count0(pop_count0),
    .pop_count1(pop_count1),
    .pop_count2(pop_count2),
    .pop_count3(pop_count3)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_pushed = 0;

  logic [DW-1:0] fq [$];
  logic [DW-1:0] exp_q [$];
  logic          hold_empty = 1'b0;
  logic [DW-1:0] word_m = '0;
  logic          infl_m = 1'b0;
  logic          err_m = 1'b0;
  logic          pushed_m = 1'b0;
  logic          pop_m = 1'b0;
  int            st_m = 0;
  logic [SW-1:0] cnt_m [4];
  logic [DW-1:0] mon_w;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [DW-1:0] w);
    logic [3:0] r;
    r = 4'b0001 << w[DW-1 -: 2];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // external FIFO: presents the popped word and the empty flag
  initial forever begin
    @(posedge clk);
    #2;
    fifo_data_out = infl_m ? word_m : DW'($urandom);
    fifo_empty    = hold_empty || fq.size() == 0;
  end

  // reference model: pop rule, 1-cycle delivery, sticky error
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_m = 0;
      err_m = 1'b0;
      infl_m = 1'b0;
      pushed_m = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) cnt_m[i] = '0;
    end else begin
      pop_m = !err_m && !fifo_empty && !(|dest_almost_full);
      pushed_m = 1'b0;
      if (infl_m && !err_m && !fifo_error) begin
        exp_q.push_back(word_m);
        pushed_m = 1'b1;
        cnt_m[word_m[DW-1 -: 2]] += 1;
      end
      if (fifo_error) st_m = 2;
      else if (st_m == 0 && pop_m) st_m = 1;
      else if (st_m == 1 && (fifo_empty || |dest_almost_full)) st_m = 0;
      if (fifo_error) err_m = 1'b1;
      infl_m = pop_m;
      if (pop_m && fq.size() > 0) word_m = fq.pop_front();
    end
  end

  // monitor: pops the scoreboard whenever a push is due or seen
  always @(negedge clk) begin
    if (push != 4'b0000 || pushed_m) begin
      if (exp_q.size() == 0) begin
        chk("push_unexpected", push, 0);
      end else begin
        mon_w = exp_q.pop_front();
        chk("push_dest", push, onehot(mon_w));
        chk("push_data", data_out, mon_w);
        n_pushed++;
      end
    end
    chk("read_enable", fifo_read_enable,
        reset && !err_m && !fifo_empty && !(|dest_almost_full));
    chk("state", state, st_m);
    chk("idle", idle, st_m == 0 && !infl_m && !pushed_m);
  end

  task automatic drain(input string name, input int maxc);
    int c = 0;
    while ((fq.size() != 0 || infl_m || exp_q.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    chk({name, "_drain_timeout"}, c < maxc, 1);
  endtask

  initial begin
    int c;

    // reset with a non-empty FIFO
    fq = '{10'b0010010001, 10'b0101100100, 10'b1001100110, 10'b1101000110};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_push", push, 0);
    chk("reset_rd", fifo_read_enable, 0);
    chk("reset_state", state, 0);
    chk("reset_idle", idle, 1);

    // drain and route the four directed words
    step();
    reset = 1'b1;
    drain("route", 20);
    @(negedge clk);
    chk("route_count", n_pushed, 4);
    chk("route_state", state, 0);
    chk("route_idle", idle, 1);

    // backpressure mid-stream
    step();
    for (int i = 0; i < 12; i++) fq.push_back(DW'($urandom));
    repeat (4) step();
    dest_almost_full = 4'b0100;
    @(negedge clk);
    chk("bp_rd_drop", fifo_read_enable, 0);
    step();
    step();
    @(negedge clk);
    chk("bp_state_idle", state, 0);
    step();
    dest_almost_full = 4'b0000;
    @(negedge clk);
    chk("bp_resume", fifo_read_enable, 1);
    drain("bp", 40);

    // error while a word is in flight
    for (int i = 0; i < 6; i++) fq.push_back(DW'($urandom));
    c = 0;
    do begin
      step();
      c++;
    end while (!infl_m && c < 20);
    chk("err_wait_timeout", c < 20, 1);
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("err_state", state, 2);
      chk("err_rd", fifo_read_enable, 0);
      chk("err_no_push", push, 0);
    end
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("err_reset_state", state, 0);
    drain("err", 40);

    // async reset while a dest-1 word is on the bus
    for (int i = 0; i < 8; i++) fq.push_back({2'b01, 8'($urandom)});
    c = 0;
    do begin
      step();
      c++;
    end while (push != 4'b0010 && c < 20);
    chk("async_wait_timeout", c < 20, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_push_clear", push, 0);
    chk("async_state", state, 0);
    step();
    reset = 1'b1;
    drain("async", 40);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step();
      if ($urandom_range(0, 1) == 0) fq.push_back(DW'($urandom));
      dest_almost_full = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      hold_empty = ($urandom_range(0, 7) == 0);
      fifo_error = ($urandom_range(0, 199) == 0);
      reset = !($urandom_range(0, 149) == 0 ||
                (err_m && $urandom_range(0, 9) == 0));
    end
    step();
    fifo_error = 1'b0;
    dest_almost_full = 4'b0000;
    hold_empty = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    drain("rand", 1000);

`ifdef ROUTER_STATS_EN
    chk("cnt_rand0", pop_count0, cnt_m[0]);
    chk("cnt_rand1", pop_count1, cnt_m[1]);
    chk("cnt_rand2", pop_count2, cnt_m[2]);
    chk("cnt_rand3", pop_count3, cnt_m[3]);
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 257; i++) fq.push_back({2'b01, 8'($urandom)});
    drain("stats", 400);
    chk("stats_cnt0", pop_count0, 0);
    chk("stats_cnt1_wrap", pop_count1, 1);
    chk("stats_cnt2", pop_count2, 0);
    chk("stats_cnt3", pop_count3, 0);
`endif

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
